// File: rtl/pipelined_datapath_fwd.sv
// Four-stage IF/RF -> EX -> MEM -> WB datapath with a valid/ready issue port.
// Define FORWARDING_EN for EX/MEM/WB bypassing; otherwise RAW hazards stall.
module pipelined_datapath_fwd #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  main_clk,
  input  logic                  main_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_we,
  input  logic [3:0]            in_alu_sel,
  input  logic                  in_use_imm,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [MEM_ADDR_W-1:0] in_mem_addr,
  input  logic                  in_mem_we,
  input  logic                  in_mem_re,
  input  logic                  in_wb_sel,
  output logic [DATA_W-1:0]     dbg_rs1_data,
  output logic [DATA_W-1:0]     dbg_rs2_data,
  output logic [DATA_W-1:0]     dbg_alu_result,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam int NMEM = 2**MEM_ADDR_W;
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic [3:0]            alu_sel;
    logic                  use_imm;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_re;
    logic                  wb_sel;
  } id_ex_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     sd;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  mem_we;
    logic                  mem_re;
    logic                  wb_sel;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } mem_wb_t;

  id_ex_t  ex_q, id_d;
  ex_mem_t mem_q, ex_d;
  mem_wb_t wb_q, wb_d;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] mem  [NMEM];

  logic              stall, accept, use2;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic [DATA_W-1:0] mem_rdata, mem_res;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  function automatic logic hit(
    input logic                  v,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return v && we && (rd == rs) && (rd != '0);
  endfunction

  // Write-first: the WB value wins over the stored word.
  function automatic logic [DATA_W-1:0] rf_read(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (rs == '0) return '0;
    if (hit(wb_q.valid, wb_q.we, wb_q.rd, rs)) return wb_q.data;
    return regs[rs];
  endfunction

  assign use2 = !in_use_imm || in_mem_we;

`ifdef FORWARDING_EN
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (hit(ex_q.valid, ex_q.reg_we, ex_q.rd, rs)) return alu_y;
    if (hit(mem_q.valid, mem_q.reg_we, mem_q.rd, rs)) return mem_res;
    return rf_read(rs);
  endfunction

  logic ex_load;
  assign ex_load = ex_q.mem_re && ex_q.wb_sel;
  assign stall = in_valid && ex_load && (
    hit(ex_q.valid, ex_q.reg_we, ex_q.rd, in_rs1) ||
    (use2 && hit(ex_q.valid, ex_q.reg_we, ex_q.rd, in_rs2)));
`else
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0] rs
  );
    return rf_read(rs);
  endfunction

  logic dep1, dep2;
  assign dep1 = hit(ex_q.valid, ex_q.reg_we, ex_q.rd, in_rs1) ||
                hit(mem_q.valid, mem_q.reg_we, mem_q.rd, in_rs1);
  assign dep2 = hit(ex_q.valid, ex_q.reg_we, ex_q.rd, in_rs2) ||
                hit(mem_q.valid, mem_q.reg_we, mem_q.rd, in_rs2);
  assign stall = in_valid && (dep1 || (use2 && dep2));
`endif

  assign in_ready = !main_rst && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rs1_val = resolve(in_rs1);
    rs2_val = resolve(in_rs2);
  end

  always_comb begin
    id_d          = '0;
    id_d.valid    = accept;
    id_d.rd       = in_rd;
    id_d.reg_we   = in_reg_we;
    id_d.alu_sel  = in_alu_sel;
    id_d.use_imm  = in_use_imm;
    id_d.imm      = in_imm;
    id_d.rs1_data = rs1_val;
    id_d.rs2_data = rs2_val;
    id_d.mem_addr = in_mem_addr;
    id_d.mem_we   = in_mem_we;
    id_d.mem_re   = in_mem_re;
    id_d.wb_sel   = in_wb_sel;
  end

  assign alu_b = ex_q.use_imm ? ex_q.imm : ex_q.rs2_data;

  always_comb begin
    alu_y = ex_q.rs1_data;
    unique case (ex_q.alu_sel)
      ALU_ADD: alu_y = ex_q.rs1_data + alu_b;
      ALU_SUB: alu_y = ex_q.rs1_data - alu_b;
      ALU_AND: alu_y = ex_q.rs1_data & alu_b;
      ALU_OR:  alu_y = ex_q.rs1_data | alu_b;
      ALU_XOR: alu_y = ex_q.rs1_data ^ alu_b;
      ALU_SLL: alu_y = ex_q.rs1_data << alu_b[SH_W-1:0];
      ALU_SRL: alu_y = ex_q.rs1_data >> alu_b[SH_W-1:0];
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}},
                        $signed(ex_q.rs1_data) < $signed(alu_b)};
      default: alu_y = ex_q.rs1_data;
    endcase
  end

  always_comb begin
    ex_d        = '0;
    ex_d.valid  = ex_q.valid;
    ex_d.rd     = ex_q.rd;
    ex_d.reg_we = ex_q.reg_we;
    ex_d.alu    = alu_y;
    ex_d.sd     = ex_q.rs2_data;
    ex_d.addr   = ex_q.mem_addr;
    ex_d.mem_we = ex_q.mem_we;
    ex_d.mem_re = ex_q.mem_re;
    ex_d.wb_sel = ex_q.wb_sel;
  end

  // Read happens before the same-cycle store lands, so a load sees the old word.
  assign mem_rdata = mem_q.mem_re ? mem[mem_q.addr] : '0;
  assign mem_res   = mem_q.wb_sel ? mem_rdata : mem_q.alu;

  always_comb begin
    wb_d       = '0;
    wb_d.valid = mem_q.valid;
    wb_d.we    = mem_q.valid && mem_q.reg_we;
    wb_d.rd    = mem_q.rd;
    wb_d.data  = mem_res;
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < NMEM; i++) mem[i] <= '0;
    end else begin
      ex_q  <= id_d;
      mem_q <= ex_d;
      wb_q  <= wb_d;
      if (hit(wb_q.valid, wb_q.we, wb_q.rd, wb_q.rd))
        regs[wb_q.rd] <= wb_q.data;
      if (mem_q.valid && mem_q.mem_we)
        mem[mem_q.addr] <= mem_q.sd;
    end
  end

  assign dbg_rs1_data   = ex_q.rs1_data;
  assign dbg_rs2_data   = ex_q.rs2_data;
  assign dbg_alu_result = mem_q.alu;
  assign wb_valid       = wb_q.valid;
  assign wb_we          = wb_q.we;
  assign wb_rd          = wb_q.rd;
  assign wb_data        = wb_q.data;
endmodule
